// File: rtl/v33_bus_responder.sv
// rtl/v33_bus_responder.sv - V33 bus slave turning CPU bus cycles into backend req/ack transactions
// Optional feature macro: BUS_TIMEOUT_EN (backend ack timeout in ACCESS)
module v33_bus_responder #(
    parameter int WAIT_MIN = 0,
    parameter bit BUS16    = 1'b1,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic        n_bcyst,
    input  logic        n_dstb,
    input  logic        r_w,
    input  logic        m_io,
    input  logic        n_ube,
    input  logic [23:0] addr,
    input  logic [15:0] cpu_dout,
    output logic        n_ready,
    output logic        bs16,
    output logic [15:0] cpu_din,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        mem_we,
    output logic        mem_io,
    input  logic [15:0] mem_rdata,
    output logic        protocol_err
);

    if (WAIT_MIN < 0 || WAIT_MIN > 15) begin : g_bad_wait_min
        $error("v33_bus_responder: WAIT_MIN must be within 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("v33_bus_responder: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_READY  = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [3:0]  wait_q,     wait_d;
    logic        ack_seen_q, ack_seen_d;
    logic        n_ready_q,  n_ready_d;
    logic        bs16_q,     bs16_d;
    logic [15:0] cpu_din_q,  cpu_din_d;
    logic        mem_req_q,  mem_req_d;
    logic [23:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic [1:0]  be_q,       be_d;
    logic        we_q,       we_d;
    logic        io_q,       io_d;
    logic        err_q,      err_d;
    logic        ack_hit;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ack_seen_d = ack_seen_q;
        n_ready_d  = n_ready_q;
        bs16_d     = bs16_q;
        cpu_din_d  = cpu_din_q;
        mem_req_d  = mem_req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        io_d       = io_q;
        err_d      = 1'b0;
        ack_hit    = ack_seen_q | mem_ack;
`ifdef BUS_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ce_1 && !n_bcyst) begin
                    addr_d     = {addr[23:1], 1'b0};
                    wdata_d    = cpu_dout;
                    be_d       = {~n_ube, ~addr[0]};
                    we_d       = ~r_w;
                    io_d       = ~m_io;
                    mem_req_d  = 1'b1;
                    bs16_d     = BUS16;
                    wait_d     = 4'(WAIT_MIN);
                    ack_seen_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
                    tmo_d      = 8'd0;
`endif
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Ack is sampled every clk; the ce_1 exit test also sees an ack on that same clk.
                if (mem_ack && !ack_seen_q) begin
                    ack_seen_d = 1'b1;
                    mem_req_d  = 1'b0;
                    if (!we_q) cpu_din_d = mem_rdata;
                end
                if (ce_1) begin
                    if (ack_hit && wait_q == 4'd0) begin
                        n_ready_d = 1'b0;
                        state_d   = S_READY;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (!ack_hit && tmo_q == TMO_LAST) begin
                        mem_req_d = 1'b0;
                        if (!we_q) cpu_din_d = 16'hFFFF;
                        n_ready_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_READY;
                    end
                    tmo_d = tmo_q + 8'd1;
`endif
                    if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                end
            end
            S_READY: begin
                if (ce_1) begin
                    n_ready_d = 1'b1;
                    state_d   = S_END;
                end
            end
            S_END: begin
                if (ce_1 && n_dstb) begin
                    bs16_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The V33 drives write data late, so keep tracking it during the data strobe.
        if (ce_2 && !n_dstb && state_q != S_IDLE && we_q) wdata_d = cpu_dout;

        if (mem_ack && state_q != S_ACCESS) err_d = 1'b1;
        if (ce_1 && !n_bcyst && state_q != S_IDLE) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            ack_seen_q <= 1'b0;
            n_ready_q  <= 1'b1;
            bs16_q     <= 1'b0;
            cpu_din_q  <= 16'd0;
            mem_req_q  <= 1'b0;
            addr_q     <= 24'd0;
            wdata_q    <= 16'd0;
            be_q       <= 2'd0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            err_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ack_seen_q <= ack_seen_d;
            n_ready_q  <= n_ready_d;
            bs16_q     <= bs16_d;
            cpu_din_q  <= cpu_din_d;
            mem_req_q  <= mem_req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            io_q       <= io_d;
            err_q      <= err_d;
`ifdef BUS_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign n_ready      = n_ready_q;
    assign bs16         = bs16_q;
    assign cpu_din      = cpu_din_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_be       = be_q;
    assign mem_we       = we_q;
    assign mem_io       = io_q;
    assign protocol_err = err_q;

endmodule
